// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the RAM/VGA devices.
// The arbiter connects through the slave modport; the master modport is the environment side.
interface bus_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_we;
    logic        m1_we;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic        m0_done;
    logic        m1_done;
    logic        m0_err;
    logic        m1_err;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic [31:0] ram_stat;
    logic [31:0] vga_stat;
    logic [31:0] ram_ctrl;
    logic [31:0] vga_ctrl;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  ram_stat, vga_stat, data_in,
        output m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
        output ram_ctrl, vga_ctrl, addr, data_out, busy
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output ram_stat, vga_stat, data_in,
        input  m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
        input  ram_ctrl, vga_ctrl, addr, data_out, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter running the four-phase ctrl/ACK handshake
// against RAM or VGA, with a saturating ACK timeout. All outputs are registered.
module bus_arbiter #(
    parameter int unsigned READ_BIT  = 0,
    parameter int unsigned WRITE_BIT = 1,
    parameter int unsigned ACK_BIT   = 0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_REL, DONE} state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam logic [31:0] RD_PIN    = 32'd1 << READ_BIT;
    localparam logic [31:0] WR_PIN    = 32'd1 << WRITE_BIT;

    state_t      r_state, w_state;
    logic        r_gnt_id, w_gnt_id;
    logic        r_gnt_vga, w_gnt_vga;
    logic        r_gnt_we, w_gnt_we;
    logic        r_last_grant, w_last_grant;
    logic [15:0] r_timer, w_timer;
    logic        r_err_pend, w_err_pend;
    logic [31:0] r_rd_cap, w_rd_cap;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_data_out, w_data_out;
    logic [31:0] r_ram_ctrl, w_ram_ctrl;
    logic [31:0] r_vga_ctrl, w_vga_ctrl;
    logic        r_m0_done, w_m0_done;
    logic        r_m1_done, w_m1_done;
    logic        r_m0_err, w_m0_err;
    logic        r_m1_err, w_m1_err;
    logic [31:0] r_m0_rdata, w_m0_rdata;
    logic [31:0] r_m1_rdata, w_m1_rdata;
    logic        r_busy, w_busy;

    logic        w_cand_valid;
    logic        w_cand_id;
    logic        w_cand_we;
    logic        w_cand_vga;
    logic        w_cand_ack;
    logic        w_gnt_ack;
    logic        w_finish;
    logic [31:0] w_cand_addr;
    logic [31:0] w_cand_wdata;
    logic [31:0] w_pin;
    logic        w_unused;

    // Only the ACK bit of each status word is consumed.
    assign w_unused = ^{bus.ram_stat, bus.vga_stat};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt_id     <= 1'b0;
            r_gnt_vga    <= 1'b0;
            r_gnt_we     <= 1'b0;
            r_last_grant <= 1'b1;
            r_timer      <= '0;
            r_err_pend   <= 1'b0;
            r_rd_cap     <= '0;
            r_addr       <= '0;
            r_data_out   <= '0;
            r_ram_ctrl   <= '0;
            r_vga_ctrl   <= '0;
            r_m0_done    <= 1'b0;
            r_m1_done    <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_gnt_id     <= w_gnt_id;
            r_gnt_vga    <= w_gnt_vga;
            r_gnt_we     <= w_gnt_we;
            r_last_grant <= w_last_grant;
            r_timer      <= w_timer;
            r_err_pend   <= w_err_pend;
            r_rd_cap     <= w_rd_cap;
            r_addr       <= w_addr;
            r_data_out   <= w_data_out;
            r_ram_ctrl   <= w_ram_ctrl;
            r_vga_ctrl   <= w_vga_ctrl;
            r_m0_done    <= w_m0_done;
            r_m1_done    <= w_m1_done;
            r_m0_err     <= w_m0_err;
            r_m1_err     <= w_m1_err;
            r_m0_rdata   <= w_m0_rdata;
            r_m1_rdata   <= w_m1_rdata;
            r_busy       <= w_busy;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_gnt_id     = r_gnt_id;
        w_gnt_vga    = r_gnt_vga;
        w_gnt_we     = r_gnt_we;
        w_last_grant = r_last_grant;
        w_timer      = r_timer;
        w_err_pend   = r_err_pend;
        w_rd_cap     = r_rd_cap;
        w_addr       = r_addr;
        w_data_out   = r_data_out;
        w_ram_ctrl   = r_ram_ctrl;
        w_vga_ctrl   = r_vga_ctrl;
        w_m0_done    = 1'b0;
        w_m1_done    = 1'b0;
        w_m0_err     = 1'b0;
        w_m1_err     = 1'b0;
        w_m0_rdata   = r_m0_rdata;
        w_m1_rdata   = r_m1_rdata;
        w_finish     = 1'b0;
        w_pin        = '0;

        // With both requesting, the master that did not win last time is the candidate.
        w_cand_valid = bus.m0_req | bus.m1_req;
        w_cand_id    = bus.m0_req ? (bus.m1_req ? ~r_last_grant : 1'b0) : 1'b1;
        w_cand_we    = w_cand_id ? bus.m1_we    : bus.m0_we;
        w_cand_addr  = w_cand_id ? bus.m1_addr  : bus.m0_addr;
        w_cand_wdata = w_cand_id ? bus.m1_wdata : bus.m0_wdata;
        w_cand_vga   = w_cand_addr[31];
        w_cand_ack   = w_cand_vga ? bus.vga_stat[ACK_BIT] : bus.ram_stat[ACK_BIT];
        w_gnt_ack    = r_gnt_vga  ? bus.vga_stat[ACK_BIT] : bus.ram_stat[ACK_BIT];

        case (r_state)
            IDLE: begin
                // A busy target stalls the candidate; the other master is not substituted.
                if (w_cand_valid && !w_cand_ack) begin
                    w_state    = WAIT_ACK;
                    w_gnt_id   = w_cand_id;
                    w_gnt_vga  = w_cand_vga;
                    w_gnt_we   = w_cand_we;
                    w_addr     = {1'b0, w_cand_addr[30:0]};
                    w_data_out = w_cand_we ? w_cand_wdata : 32'd0;
                    w_pin      = w_cand_we ? WR_PIN : RD_PIN;
                    w_ram_ctrl = w_cand_vga ? 32'd0 : w_pin;
                    w_vga_ctrl = w_cand_vga ? w_pin : 32'd0;
                    w_timer    = '0;
                end
            end
            WAIT_ACK: begin
                if (w_gnt_ack) begin
                    if (!r_gnt_we) w_rd_cap = bus.data_in;
                    w_ram_ctrl = '0;
                    w_vga_ctrl = '0;
                    w_timer    = '0;
                    w_state    = WAIT_REL;
                end else if (r_timer == TIMEOUT_W) begin
                    w_ram_ctrl = '0;
                    w_vga_ctrl = '0;
                    w_err_pend = 1'b1;
                    w_finish   = 1'b1;
                    w_state    = DONE;
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            WAIT_REL: begin
                if (!w_gnt_ack) begin
                    w_finish = 1'b1;
                    w_state  = DONE;
                end else if (r_timer == TIMEOUT_W) begin
                    w_err_pend = 1'b1;
                    w_finish   = 1'b1;
                    w_state    = DONE;
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            DONE: begin
                w_last_grant = r_gnt_id;
                w_addr       = '0;
                w_data_out   = '0;
                w_err_pend   = 1'b0;
                w_state      = IDLE;
            end
            default: w_state = IDLE;
        endcase

        // Completion is registered on entry to DONE so done/err/rdata are visible during DONE.
        if (w_finish) begin
            if (r_gnt_id) begin
                w_m1_done = 1'b1;
                w_m1_err  = w_err_pend;
                if (!w_err_pend && !r_gnt_we) w_m1_rdata = w_rd_cap;
            end else begin
                w_m0_done = 1'b1;
                w_m0_err  = w_err_pend;
                if (!w_err_pend && !r_gnt_we) w_m0_rdata = w_rd_cap;
            end
        end

        w_busy = (w_state != IDLE);
    end

    assign bus.m0_done  = r_m0_done;
    assign bus.m1_done  = r_m1_done;
    assign bus.m0_err   = r_m0_err;
    assign bus.m1_err   = r_m1_err;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;
    assign bus.ram_ctrl = r_ram_ctrl;
    assign bus.vga_ctrl = r_vga_ctrl;
    assign bus.addr     = r_addr;
    assign bus.data_out = r_data_out;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: RAM/VGA ACK models with programmable delays,
// one task per scenario, inline comparisons against hand-derived cycle indices.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic ram_ack, vga_ack;
    logic ram_auto, vga_auto;
    int   ram_up, ram_dn, vga_up, vga_dn;
    int   ram_cnt, vga_cnt;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bus_arbiter_if bus();

    bus_arbiter #(.READ_BIT(0), .WRITE_BIT(1), .ACK_BIT(0), .TIMEOUT(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    assign bus.ram_stat = {31'd0, ram_ack};
    assign bus.vga_stat = {31'd0, vga_ack};

    // Device models: ACK rises after the pin has been seen for *_up edges, falls *_dn edges after clear.
    always @(posedge clk) begin
        #1;
        if (ram_auto) begin
            if (bus.ram_ctrl != 0 && !ram_ack) begin
                ram_cnt++;
                if (ram_cnt >= ram_up) begin ram_ack = 1'b1; ram_cnt = 0; end
            end else if (bus.ram_ctrl == 0 && ram_ack) begin
                ram_cnt++;
                if (ram_cnt >= ram_dn) begin ram_ack = 1'b0; ram_cnt = 0; end
            end else ram_cnt = 0;
        end
        if (vga_auto) begin
            if (bus.vga_ctrl != 0 && !vga_ack) begin
                vga_cnt++;
                if (vga_cnt >= vga_up) begin vga_ack = 1'b1; vga_cnt = 0; end
            end else if (bus.vga_ctrl == 0 && vga_ack) begin
                vga_cnt++;
                if (vga_cnt >= vga_dn) begin vga_ack = 1'b0; vga_cnt = 0; end
            end else vga_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
        bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
        bus.data_in = 0;
        ram_ack = 0; vga_ack = 0; ram_auto = 0; vga_auto = 0;
        ram_up = 1; ram_dn = 1; vga_up = 1; vga_dn = 1; ram_cnt = 0; vga_cnt = 0;
        #22;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_cmp++; if (bus.ram_ctrl !== 32'd0) begin n_fail++; $display("FAIL reset_ram_ctrl got %h want 0", bus.ram_ctrl); end
        n_cmp++; if (bus.vga_ctrl !== 32'd0) begin n_fail++; $display("FAIL reset_vga_ctrl got %h want 0", bus.vga_ctrl); end
        n_cmp++; if ({bus.addr, bus.data_out} !== 64'd0) begin n_fail++; $display("FAIL reset_bus got %h/%h want 0/0", bus.addr, bus.data_out); end
        n_cmp++; if ({bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err} !== 4'd0) begin n_fail++;
            $display("FAIL reset_done_err got %b want 0000", {bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}); end
        n_cmp++; if ({bus.m0_rdata, bus.m1_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0/0", bus.m0_rdata, bus.m1_rdata); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_busy got %0b want 0", bus.busy); end
    endtask

    task automatic test_m0_write();
        int ctrl_cyc = 0, done_idx = 0, done_cnt = 0;
        bit bad_vga = 0, bad_bus = 0, m1_seen = 0;
        logic err_at = 1'bx;
        ram_up = 3; ram_dn = 2; ram_auto = 1;
        bus.m0_we = 1; bus.m0_addr = 32'd5; bus.m0_wdata = 32'd5; bus.m0_req = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.vga_ctrl != 0) bad_vga = 1;
            if (bus.m1_done) m1_seen = 1;
            if (bus.ram_ctrl != 0) begin
                ctrl_cyc++;
                if (bus.ram_ctrl !== 32'h2) bad_bus = 1;
            end
            if (bus.busy && (bus.addr !== 32'd5 || bus.data_out !== 32'd5)) bad_bus = 1;
            if (bus.m0_done) begin
                done_cnt++;
                if (done_idx == 0) done_idx = i;
                err_at = bus.m0_err;
                bus.m0_req = 0;
            end
        end
        ram_auto = 0;
        n_cmp++; if (ctrl_cyc != 3) begin n_fail++; $display("FAIL wr_ctrl_cycles got %0d want 3", ctrl_cyc); end
        n_cmp++; if (done_idx != 6) begin n_fail++; $display("FAIL wr_done_cycle got %0d want 6", done_idx); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL wr_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (err_at !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", err_at); end
        n_cmp++; if (bad_bus) begin n_fail++; $display("FAIL wr_bus_stable got unstable want ctrl=2 addr=5 data=5"); end
        n_cmp++; if (bad_vga || m1_seen) begin n_fail++; $display("FAIL wr_side_effects got vga=%0b m1_done=%0b want 0/0", bad_vga, m1_seen); end
        n_cmp++; if ({bus.addr, bus.data_out, 31'd0, bus.busy} !== 96'd0) begin n_fail++;
            $display("FAIL wr_after_done got addr=%h data=%h busy=%b want 0/0/0", bus.addr, bus.data_out, bus.busy); end
    endtask

    task automatic test_m1_read();
        int done_idx = 0;
        bit m0_seen = 0;
        logic [31:0] rdata_at = 'x;
        logic err_at = 1'bx;
        vga_up = 2; vga_dn = 1; vga_auto = 1;
        bus.data_in = 32'h41;
        bus.m1_we = 0; bus.m1_addr = 32'h8000_0010; bus.m1_req = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.m0_done) m0_seen = 1;
            if (i == 1) begin
                n_cmp++; if (bus.vga_ctrl !== 32'h1) begin n_fail++; $display("FAIL rd_vga_ctrl got %h want 1", bus.vga_ctrl); end
                n_cmp++; if (bus.addr !== 32'h10) begin n_fail++; $display("FAIL rd_addr got %h want 10", bus.addr); end
                n_cmp++; if ({bus.ram_ctrl, bus.data_out} !== 64'd0) begin n_fail++;
                    $display("FAIL rd_ram_ctrl_data got %h/%h want 0/0", bus.ram_ctrl, bus.data_out); end
            end
            if (bus.m1_done) begin
                done_idx = i; rdata_at = bus.m1_rdata; err_at = bus.m1_err;
                bus.m1_req = 0; bus.data_in = 32'd0;
            end
        end
        vga_auto = 0;
        n_cmp++; if (done_idx != 4) begin n_fail++; $display("FAIL rd_done_cycle got %0d want 4", done_idx); end
        n_cmp++; if (rdata_at !== 32'h41 || err_at !== 1'b0) begin n_fail++; $display("FAIL rd_rdata got %h err %b want 41 err 0", rdata_at, err_at); end
        n_cmp++; if (bus.m1_rdata !== 32'h41) begin n_fail++; $display("FAIL rd_rdata_hold got %h want 41", bus.m1_rdata); end
        n_cmp++; if (m0_seen || bus.m0_rdata !== 32'd0) begin n_fail++; $display("FAIL rd_m0_untouched got done=%0b rdata=%h want 0/0", m0_seen, bus.m0_rdata); end
    endtask

    task automatic test_round_robin();
        int ids[4];
        int idx[4];
        int n = 0;
        bit both = 0;
        ram_up = 2; ram_dn = 1; ram_auto = 1;
        bus.data_in = 32'h0000_BEEF;
        bus.m0_we = 0; bus.m0_addr = 32'h100; bus.m1_we = 0; bus.m1_addr = 32'h200;
        bus.m0_req = 1; bus.m1_req = 1;
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (bus.m0_done && bus.m1_done) both = 1;
            if (bus.m0_done || bus.m1_done) begin
                if (n < 4) begin ids[n] = bus.m1_done ? 1 : 0; idx[n] = i; end
                n++;
                if (n == 4) begin bus.m0_req = 0; bus.m1_req = 0; end
            end
        end
        ram_auto = 0;
        n_cmp++; if (n != 4 || both) begin n_fail++; $display("FAIL rr_done_count got %0d both=%0b want 4/0", n, both); end
        n_cmp++; if (ids[0] != 0 || ids[1] != 1 || ids[2] != 0 || ids[3] != 1) begin n_fail++;
            $display("FAIL rr_order got %0d%0d%0d%0d want 0101", ids[0], ids[1], ids[2], ids[3]); end
        n_cmp++; if (idx[0] != 4) begin n_fail++; $display("FAIL rr_first_done got %0d want 4", idx[0]); end
        for (int k = 1; k < 4; k++) begin
            n_cmp++; if (idx[k] - idx[k-1] != 5) begin n_fail++; $display("FAIL rr_spacing_%0d got %0d want 5", k, idx[k] - idx[k-1]); end
        end
        n_cmp++; if (bus.m0_rdata !== 32'hBEEF || bus.m1_rdata !== 32'hBEEF) begin n_fail++;
            $display("FAIL rr_rdata got %h/%h want beef/beef", bus.m0_rdata, bus.m1_rdata); end
    endtask

    task automatic test_timeout();
        int ctrl_cyc = 0, done_idx = 0;
        bit bad_pin = 0;
        logic err_at = 1'bx;
        logic [31:0] rdata_at = 'x;
        ram_auto = 0; ram_ack = 0;
        bus.data_in = 32'hDEAD_0000;
        bus.m0_we = 0; bus.m0_addr = 32'h20; bus.m0_req = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.ram_ctrl != 0) begin
                ctrl_cyc++;
                if (bus.ram_ctrl !== 32'h1) bad_pin = 1;
            end
            if (bus.m0_done) begin
                done_idx = i; err_at = bus.m0_err; rdata_at = bus.m0_rdata;
                bus.m0_req = 0;
            end
        end
        n_cmp++; if (ctrl_cyc != 9 || bad_pin) begin n_fail++; $display("FAIL to_ctrl_cycles got %0d bad=%0b want 9/0", ctrl_cyc, bad_pin); end
        n_cmp++; if (done_idx != 10) begin n_fail++; $display("FAIL to_done_cycle got %0d want 10", done_idx); end
        n_cmp++; if (err_at !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", err_at); end
        n_cmp++; if (rdata_at !== 32'hBEEF) begin n_fail++; $display("FAIL to_rdata_kept got %h want beef", rdata_at); end
    endtask

    task automatic test_reset_mid();
        int m0_idx = 0, m1_idx = 0;
        bit m1_early = 0;
        ram_auto = 0; ram_ack = 0;
        bus.m1_we = 1; bus.m1_addr = 32'h40; bus.m1_wdata = 32'h77; bus.m1_req = 1;
        tick();
        n_cmp++; if (bus.ram_ctrl !== 32'h2) begin n_fail++; $display("FAIL rst_pre_ctrl got %h want 2", bus.ram_ctrl); end
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus.ram_ctrl, bus.vga_ctrl} !== 64'd0) begin n_fail++;
            $display("FAIL rst_mid_ctrl got %h/%h want 0/0", bus.ram_ctrl, bus.vga_ctrl); end
        n_cmp++; if ({bus.addr, bus.data_out} !== 64'd0) begin n_fail++;
            $display("FAIL rst_mid_bus got %h/%h want 0/0", bus.addr, bus.data_out); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.m0_rdata !== 32'd0) begin n_fail++;
            $display("FAIL rst_mid_busy_rdata got %b/%h want 0/0", bus.busy, bus.m0_rdata); end
        tick();
        if (bus.m1_done) m1_early = 1;
        tick();
        if (bus.m1_done) m1_early = 1;
        rst = 1'b0;
        ram_up = 2; ram_dn = 1; ram_auto = 1;
        bus.m0_we = 1; bus.m0_addr = 32'd1; bus.m0_wdata = 32'd9; bus.m0_req = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.m0_done && m0_idx == 0) begin m0_idx = i; bus.m0_req = 0; end
            if (bus.m1_done && m1_idx == 0) begin m1_idx = i; bus.m1_req = 0; end
        end
        ram_auto = 0;
        n_cmp++; if (m1_early) begin n_fail++; $display("FAIL rst_no_done got m1_done want none"); end
        n_cmp++; if (m0_idx != 4 || m1_idx != 9) begin n_fail++; $display("FAIL rst_then_order got m0@%0d m1@%0d want m0@4 m1@9", m0_idx, m1_idx); end
    endtask

    task automatic test_ack_held();
        int m0_idx = 0, m1_idx = 0;
        bit stalled_bad = 0;
        ram_auto = 0; ram_ack = 1;
        vga_up = 2; vga_dn = 1; vga_auto = 1;
        bus.data_in = 32'h5A;
        bus.m0_we = 0; bus.m0_addr = 32'd3; bus.m0_req = 1;
        bus.m1_we = 0; bus.m1_addr = 32'h8000_0004; bus.m1_req = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (bus.ram_ctrl != 0 || bus.vga_ctrl != 0 || bus.busy) stalled_bad = 1;
        end
        n_cmp++; if (stalled_bad) begin n_fail++; $display("FAIL held_no_grant got a grant want none while ram ack high"); end
        ram_ack = 0;
        ram_up = 2; ram_dn = 1; ram_auto = 1;
        tick();
        n_cmp++; if (bus.ram_ctrl !== 32'h1 || bus.vga_ctrl !== 32'd0) begin n_fail++;
            $display("FAIL held_grant_edge got ram %h vga %h want 1/0", bus.ram_ctrl, bus.vga_ctrl); end
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (bus.m0_done && m0_idx == 0) begin m0_idx = i; bus.m0_req = 0; end
            if (bus.m1_done && m1_idx == 0) begin m1_idx = i; bus.m1_req = 0; end
        end
        ram_auto = 0; vga_auto = 0;
        n_cmp++; if (m0_idx != 4 || m1_idx != 9) begin n_fail++; $display("FAIL held_order got m0@%0d m1@%0d want m0@4 m1@9", m0_idx, m1_idx); end
        n_cmp++; if (bus.m0_rdata !== 32'h5A || bus.m1_rdata !== 32'h5A) begin n_fail++;
            $display("FAIL held_rdata got %h/%h want 5a/5a", bus.m0_rdata, bus.m1_rdata); end
    endtask

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_ack_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and sequencer for the motherboard system bus. It takes read/write requests from two masters (m0: CPU core, m1: DMA/VGA-refresh engine), decodes each request's target as RAM or VGA, and drives the shared addr/data_out bus and the target's ctrl word. It runs the four-phase ctrl/ACK handshake to completion, with round-robin fairness and an ACK timeout. It sits between the masters and the RAM/VGA device models, in place of hand-sequenced bus states.

## Interface
Parameters:
- READ_BIT, default 0: bit index of the read pin in ram_ctrl/vga_ctrl.
- WRITE_BIT, default 1: bit index of the write pin in ram_ctrl/vga_ctrl.
- ACK_BIT, default 0: bit index of ACK in ram_stat/vga_stat.
- TIMEOUT, default 255: maximum cycles spent in either wait state before abort (1..65535).

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- m0_req, m1_req  in  1  request level; held until that master's done.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  bit31 = 1 selects VGA, else RAM.
- m0_wdata, m1_wdata  in  32  write data.
- m0_done, m1_done  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  valid with done; 1 = timed out.
- m0_rdata, m1_rdata  out  32  read data, valid from done onward, held until next completion for that master.
- ram_stat, vga_stat  in  32  device status words; only ACK_BIT is used.
- ram_ctrl, vga_ctrl  out  32  device control words; only READ_BIT/WRITE_BIT are ever set.
- addr  out  32  bus address = {1'b0, granted addr[30:0]}.
- data_in  in  32  bus read data.
- data_out  out  32  bus write data.
- busy  out  1  high in any state other than IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0; state = IDLE; last_grant = m1, so m0 wins first.
- States are IDLE, WAIT_ACK, WAIT_REL, DONE.
- IDLE: candidate selection.
  - Only one master requesting: that master is the candidate.
  - Both requesting: the master not equal to last_grant.
  - A candidate is granted only if its target's stat[ACK_BIT] == 0. Otherwise wait in IDLE; the other master is not substituted.
  - On grant: latch master id, target, and we. Drive addr and data_out (write: wdata; read: 0). Set ctrl[WRITE_BIT] or ctrl[READ_BIT] on the target. Clear the timer. Go to WAIT_ACK.
- WAIT_ACK:
  - Target ACK sampled 1: capture data_in if read. Clear the target ctrl word. Clear the timer. Go to WAIT_REL.
  - Timer == TIMEOUT: clear ctrl, set err_pending, go to DONE.
  - Otherwise: timer +1.
- WAIT_REL:
  - Target ACK sampled 0: go to DONE.
  - Timer == TIMEOUT: set err_pending, go to DONE.
  - Otherwise: timer +1.
- DONE: pulse the granted master's done (with err = err_pending). Update that master's rdata on a successful read only. Set last_grant = granted id. Clear addr, data_out, err_pending. Return to IDLE unconditionally; no arbitration happens in DONE.
- Invariants:
  - At most one of ram_ctrl/vga_ctrl is nonzero.
  - At most one pin is set in that word.
  - addr and data_out are stable from the grant edge until DONE.
- Masters must deassert or change req by the edge that ends DONE. A req still high in the following IDLE cycle is a new request.
- Timer is 16 bits and never wraps, because it saturates at TIMEOUT.
- rst at any point, including mid-handshake: all outputs drop to 0 asynchronously, state = IDLE, no done is issued. The aborted master must re-request.

## Timing
- Grant edge is E0: ctrl pin, addr, and data_out are visible after E0. busy goes high after E0.
- ACK rising sampled at edge Ea: ctrl clears after Ea.
- ACK low sampled at edge Er: done high for the cycle after Er.
- Minimum latency from req to done: 4 cycles, with ACK responding in 1 cycle each way.
- Back-to-back transactions: one idle cycle (the IDLE following DONE) between them.
- Timeout: ctrl is held for exactly TIMEOUT+1 cycles in WAIT_ACK, then done/err pulse 1 cycle later.

## Test plan
- m0 write, addr 5, wdata 5; RAM ACKs 3 cycles after the pin and drops 2 cycles after clear -> ram_ctrl = 0x2 until ACK sampled, addr = 5, data_out = 5 stable; m0_done for 1 cycle, m0_err = 0; vga_ctrl = 0 throughout.
- m1 read, addr 0x8000_0010; VGA ACKs with data_in = 0x41 -> vga_ctrl = 0x1, addr = 0x10; m1_rdata = 0x41 at m1_done; m0 outputs untouched.
- Both masters request continuously (reads, RAM ACK in 1 cycle) -> grant order m0, m1, m0, m1 across 4 transactions; each done spaced 5 cycles apart.
- TIMEOUT = 8, m0 read to RAM, never ACKed -> ram_ctrl high for 9 cycles, then cleared; m0_done with m0_err = 1; m0_rdata unchanged.
- rst asserted mid-clock during WAIT_ACK of an m1 write -> ram_ctrl, vga_ctrl, addr, data_out, busy = 0 before the next edge; no m1_done; after release, m0 request is served first.
- ram_stat ACK held high when m0 requests RAM -> no grant and ram_ctrl = 0 while ACK is high; grant occurs the edge after ACK is sampled low.
